// File: rtl/decode_issue_buffer_if.sv
// rtl/decode_issue_buffer_if.sv - fetch/issue handshake bundle for decode_issue_buffer
interface decode_issue_buffer_if #(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int DEPTH       = 4,
    parameter int BTB_WAY_W   = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                   i_valid;
    logic                   o_ready;
    logic [INSTR_WIDTH-1:0] i_instruction;
    logic [ADDR_WIDTH-1:0]  i_pc;
    logic [ADDR_WIDTH-1:0]  i_pc_target_addr_pred;
    logic [BTB_WAY_W-1:0]   i_btb_way;
    logic                   i_branch_pred_taken;
    logic                   i_flush;
    logic                   i_wb_we;
    logic [REG_ADDR_W-1:0]  i_wb_rd_addr;
    logic                   o_valid;
    logic                   i_ready;
    logic [INSTR_WIDTH-1:0] o_instruction;
    logic [ADDR_WIDTH-1:0]  o_pc;
    logic [ADDR_WIDTH-1:0]  o_pc_plus4;
    logic [REG_ADDR_W-1:0]  o_rs1_addr;
    logic [REG_ADDR_W-1:0]  o_rs2_addr;
    logic [REG_ADDR_W-1:0]  o_rd_addr;
    logic [ADDR_WIDTH-1:0]  o_pc_target_addr_pred;
    logic [BTB_WAY_W-1:0]   o_btb_way;
    logic                   o_branch_pred_taken;
    logic                   o_hazard_stall;
    logic [CW-1:0]          o_count;

    modport slave (
        input  i_valid, i_instruction, i_pc, i_pc_target_addr_pred, i_btb_way,
               i_branch_pred_taken, i_flush, i_wb_we, i_wb_rd_addr, i_ready,
        output o_ready, o_valid, o_instruction, o_pc, o_pc_plus4, o_rs1_addr,
               o_rs2_addr, o_rd_addr, o_pc_target_addr_pred, o_btb_way,
               o_branch_pred_taken, o_hazard_stall, o_count
    );

    modport master (
        output i_valid, i_instruction, i_pc, i_pc_target_addr_pred, i_btb_way,
               i_branch_pred_taken, i_flush, i_wb_we, i_wb_rd_addr, i_ready,
        input  o_ready, o_valid, o_instruction, o_pc, o_pc_plus4, o_rs1_addr,
               o_rs2_addr, o_rd_addr, o_pc_target_addr_pred, o_btb_way,
               o_branch_pred_taken, o_hazard_stall, o_count
    );
endinterface

// File: rtl/decode_issue_buffer.sv
// rtl/decode_issue_buffer.sv - fetch-to-decode FIFO with load-use scoreboard gating the head
module decode_issue_buffer #(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int DEPTH       = 4,
    parameter int BTB_WAY_W   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    decode_issue_buffer_if.slave  bus
);
    localparam int NREG = 2 ** REG_ADDR_W;
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam logic [6:0] OP_LOAD = 7'b0000011;

    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];
    logic [ADDR_WIDTH-1:0]  tgt_mem   [DEPTH];
    logic [BTB_WAY_W-1:0]   way_mem   [DEPTH];
    logic                   taken_mem [DEPTH];

    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [NREG-1:0] busy, busy_next;

    logic                   nonempty, full, blocked, push, pop, load_issue;
    logic [INSTR_WIDTH-1:0] head_instr;
    logic [ADDR_WIDTH-1:0]  head_pc;
    logic [REG_ADDR_W-1:0]  rs1, rs2, rd;

    assign nonempty   = (count != '0);
    assign full       = (count == CW'(DEPTH));
    assign head_instr = nonempty ? instr_mem[rd_ptr] : '0;
    assign head_pc    = nonempty ? pc_mem[rd_ptr]    : '0;
    assign rs1        = head_instr[19:15];
    assign rs2        = head_instr[24:20];
    assign rd         = head_instr[11:7];

    // busy[0] is held at zero, so x0 operands never block
    assign blocked    = nonempty & (busy[rs1] | busy[rs2] | busy[rd]);
    assign push       = bus.i_valid & ~full & ~bus.i_flush;
    assign pop        = bus.o_valid & bus.i_ready & ~bus.i_flush;
    assign load_issue = pop & (head_instr[6:0] == OP_LOAD) & (rd != '0);

    always_comb begin
        busy_next = busy;
        if (bus.i_wb_we)
            busy_next[bus.i_wb_rd_addr] = 1'b0;
        // the issuing load is younger than any writeback landing this cycle
        if (load_issue)
            busy_next[rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            busy   <= '0;
        end else begin
            busy <= busy_next;
            if (bus.i_flush) begin
                rd_ptr <= wr_ptr;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                if (push && !pop)
                    count <= count + CW'(1);
                else if (pop && !push)
                    count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= bus.i_instruction;
            pc_mem[wr_ptr]    <= bus.i_pc;
            tgt_mem[wr_ptr]   <= bus.i_pc_target_addr_pred;
            way_mem[wr_ptr]   <= bus.i_btb_way;
            taken_mem[wr_ptr] <= bus.i_branch_pred_taken;
        end
    end

    assign bus.o_ready               = ~full;
    assign bus.o_valid               = nonempty & ~blocked;
    assign bus.o_hazard_stall        = blocked;
    assign bus.o_count               = count;
    assign bus.o_instruction         = head_instr;
    assign bus.o_pc                  = head_pc;
    assign bus.o_pc_plus4            = nonempty ? head_pc + ADDR_WIDTH'(4) : '0;
    assign bus.o_rs1_addr            = rs1;
    assign bus.o_rs2_addr            = rs2;
    assign bus.o_rd_addr             = rd;
    assign bus.o_pc_target_addr_pred = nonempty ? tgt_mem[rd_ptr]   : '0;
    assign bus.o_btb_way             = nonempty ? way_mem[rd_ptr]   : '0;
    assign bus.o_branch_pred_taken   = nonempty ? taken_mem[rd_ptr] : 1'b0;
endmodule

// File: tb/tb_decode_issue_buffer.sv
// tb/tb_decode_issue_buffer.sv - randomized and directed bench with a queue-based reference model
module tb_decode_issue_buffer;
    localparam int AW = 64, IW = 32, RW = 5, DEPTH = 4, BW = 2;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] LD3  = 32'h0000_B183;
    localparam logic [31:0] ADD5 = 32'h0041_82B3;

    logic clk = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    decode_issue_buffer_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .REG_ADDR_W(RW),
                             .DEPTH(DEPTH), .BTB_WAY_W(BW)) bus();
    decode_issue_buffer #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .REG_ADDR_W(RW),
                          .DEPTH(DEPTH), .BTB_WAY_W(BW)) dut (
        .i_clk (clk),
        .i_arst(arst),
        .bus   (bus)
    );

    typedef struct {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
        logic [AW-1:0] tgt;
        logic [BW-1:0] way;
        logic          taken;
    } pkt_t;

    pkt_t q[$];
    bit   busy_m[32];
    bit   ev_now;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    task automatic check_outputs();
        pkt_t h;
        logic [4:0] r1, r2, rd;
        bit blk;
        h = '{instr: '0, pc: '0, tgt: '0, way: '0, taken: 1'b0};
        blk = 0;
        if (q.size() != 0) begin
            h  = q[0];
            r1 = h.instr[19:15];
            r2 = h.instr[24:20];
            rd = h.instr[11:7];
            blk = (r1 != 0 && busy_m[r1]) || (r2 != 0 && busy_m[r2]) || (rd != 0 && busy_m[rd]);
        end
        ev_now = (q.size() != 0) && !blk;
        check("valid", bus.o_valid, ev_now);
        check("stall", bus.o_hazard_stall, (q.size() != 0) && blk);
        check("ready", bus.o_ready, q.size() != DEPTH);
        check("count", bus.o_count, q.size());
        check("instr", bus.o_instruction, h.instr);
        check("pc", bus.o_pc, h.pc);
        check("pc_plus4", bus.o_pc_plus4, (q.size() != 0) ? h.pc + 64'd4 : 64'd0);
        check("rs1", bus.o_rs1_addr, h.instr[19:15]);
        check("rs2", bus.o_rs2_addr, h.instr[24:20]);
        check("rd", bus.o_rd_addr, h.instr[11:7]);
        check("tgt", bus.o_pc_target_addr_pred, h.tgt);
        check("way", bus.o_btb_way, h.way);
        check("taken", bus.o_branch_pred_taken, h.taken);
    endtask

    task automatic step(input bit v, input logic [31:0] ins, input logic [63:0] pc, input bit r,
                        input bit fl, input bit we, input logic [4:0] wrd);
        pkt_t p, h;
        bit push, pop;
        @(negedge clk);
        p = '{instr: ins, pc: pc, tgt: pc ^ 64'hA5A5_0000_5A5A_0F0F, way: pc[3:2], taken: pc[2]};
        bus.i_valid = v;
        bus.i_instruction = p.instr;
        bus.i_pc = p.pc;
        bus.i_pc_target_addr_pred = p.tgt;
        bus.i_btb_way = p.way;
        bus.i_branch_pred_taken = p.taken;
        bus.i_ready = r;
        bus.i_flush = fl;
        bus.i_wb_we = we;
        bus.i_wb_rd_addr = wrd;
        #1;
        check_outputs();
        push = v && (q.size() != DEPTH) && !fl;
        pop  = ev_now && r && !fl;
        if (fl) q.delete();
        else begin
            if (pop) h = q.pop_front();
            if (push) q.push_back(p);
        end
        if (we) busy_m[wrd] = 0;
        if (pop && h.instr[6:0] == 7'b0000011 && h.instr[11:7] != 0) busy_m[h.instr[11:7]] = 1;
        @(posedge clk);
    endtask

    task automatic idle(input bit r);
        step(0, NOP, 64'h0, r, 0, 0, 5'd0);
    endtask

    logic [63:0] rpc;
    logic [31:0] rins;
    logic [6:0]  rop;

    initial begin
        bus.i_valid = 0; bus.i_instruction = '0; bus.i_pc = '0; bus.i_pc_target_addr_pred = '0;
        bus.i_btb_way = '0; bus.i_branch_pred_taken = 0; bus.i_ready = 0; bus.i_flush = 0;
        bus.i_wb_we = 0; bus.i_wb_rd_addr = '0;
        #7;
        check_outputs();
        @(negedge clk);
        arst = 0;

        // fill to full, fifth push dropped
        for (int i = 0; i < 5; i++) step(1, NOP, 64'h1000 + 64'(4 * i), 0, 0, 0, 5'd0);
        #1;
        check("full_count", bus.o_count, 4);
        check("full_ready", bus.o_ready, 0);
        check("full_pc", bus.o_pc, 64'h1000);
        check("full_pc4", bus.o_pc_plus4, 64'h1004);

        // streaming across the pointer wrap
        for (int i = 0; i < 8; i++) step(1, NOP, 64'h1010 + 64'(4 * i), 1, 0, 0, 5'd0);
        for (int i = 0; i < 5; i++) idle(1);

        // load-use stall and writeback release
        step(1, LD3, 64'h2000, 0, 0, 0, 5'd0);
        step(1, ADD5, 64'h2004, 0, 0, 0, 5'd0);
        idle(1);
        #1;
        check("lu_valid", bus.o_valid, 0);
        check("lu_stall", bus.o_hazard_stall, 1);
        step(0, NOP, 64'h0, 0, 0, 1, 5'd3);
        #1;
        check("wb_valid", bus.o_valid, 1);
        idle(1);

        // load to x0 never stalls; same-cycle set beats clear
        step(1, 32'h0000_3003, 64'h2100, 0, 0, 0, 5'd0);
        step(1, 32'h0000_0333, 64'h2104, 0, 0, 0, 5'd0);
        idle(1);
        #1;
        check("x0_stall", bus.o_hazard_stall, 0);
        idle(1);
        step(1, LD3, 64'h2200, 0, 0, 0, 5'd0);
        step(1, ADD5, 64'h2204, 0, 0, 0, 5'd0);
        step(0, NOP, 64'h0, 1, 0, 1, 5'd3);
        #1;
        check("setwins_stall", bus.o_hazard_stall, 1);
        step(0, NOP, 64'h0, 0, 0, 1, 5'd3);
        idle(1);

        // flush keeps busy bits
        step(1, LD3, 64'h2300, 1, 0, 0, 5'd0);
        idle(1);
        for (int i = 0; i < 3; i++) step(1, NOP, 64'h2400 + 64'(4 * i), 0, 0, 0, 5'd0);
        step(1, NOP, 64'h2500, 1, 1, 0, 5'd0);
        #1;
        check("flush_count", bus.o_count, 0);
        check("flush_valid", bus.o_valid, 0);
        check("flush_ready", bus.o_ready, 1);
        step(1, ADD5, 64'h2600, 0, 0, 0, 5'd0);
        #1;
        check("flush_busy", bus.o_hazard_stall, 1);
        step(0, NOP, 64'h0, 0, 0, 1, 5'd3);
        idle(1);

        // asynchronous reset mid-stream with busy[7]
        step(1, 32'h0000_0383, 64'h2700, 0, 0, 0, 5'd0);
        idle(1);
        step(1, NOP, 64'h2800, 0, 0, 0, 5'd0);
        step(1, NOP, 64'h2804, 0, 0, 0, 5'd0);
        @(negedge clk);
        bus.i_valid = 0; bus.i_ready = 0; bus.i_wb_we = 0; bus.i_flush = 0;
        #2;
        arst = 1;
        #1;
        q.delete();
        for (int i = 0; i < 32; i++) busy_m[i] = 0;
        check_outputs();
        check("rst_count", bus.o_count, 0);
        @(negedge clk);
        arst = 0;
        step(1, 32'h0003_8093, 64'h3000, 0, 0, 0, 5'd0);
        #1;
        check("rst_head_pc", bus.o_pc, 64'h3000);
        check("rst_head_valid", bus.o_valid, 1);
        idle(1);

        // randomized traffic
        rpc = 64'h8000;
        for (int i = 0; i < 600; i++) begin
            rop  = ($urandom_range(0, 2) == 0) ? 7'b0000011 : 7'b0110011;
            rins = {7'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'd0,
                    5'($urandom_range(0, 7)), rop};
            step($urandom_range(0, 3) != 0, rins, rpc, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)));
            rpc = rpc + 64'd4;
        end
        for (int i = 1; i < 32; i++) step(0, NOP, 64'h0, 1, 0, 1, 5'(i));
        for (int i = 0; i < 6; i++) idle(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
